// File: rtl/eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_ctrl
// Description : Frame-level sequencer for the RMII receive CRC checker:
//               length/timeout policy, verdict pulses, cksum re-arm, counters.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_ctrl #(
  parameter int MIN_BYTES = 8,
  parameter int MAX_BYTES = 1522,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  input  logic             ck_done,
  input  logic             ck_kill,
  output logic             ck_rst,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic [2:0]       bad_cause,
  output logic [10:0]      frame_bytes,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count,
  output logic             busy
);

  localparam int SAT_DIBITS = 4 * (MAX_BYTES + 1);
  localparam int DW         = $clog2(SAT_DIBITS + 1);
  localparam int TW         = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] C_SAT       = DW'(SAT_DIBITS);
  localparam logic [DW-1:0] C_MIN_BYTES = DW'(MIN_BYTES);
  localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [2:0] C_CAUSE_CRC     = 3'd0;
  localparam logic [2:0] C_CAUSE_RUNT    = 3'd1;
  localparam logic [2:0] C_CAUSE_GIANT   = 3'd2;
  localparam logic [2:0] C_CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] C_CAUSE_ALIGN   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    WAIT_CK = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             prev_axiiv_q;
  logic [DW-1:0]    dibit_cnt_q, dibit_cnt_d;
  logic             giant_q, giant_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ck_rst_q, ck_rst_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_bad_q, frame_bad_d;
  logic [2:0]       bad_cause_q, bad_cause_d;
  logic [10:0]      frame_bytes_q, frame_bytes_d;
  logic [CNT_W-1:0] good_count_q, good_count_d;
  logic [CNT_W-1:0] bad_count_q, bad_count_d;
  logic             busy_q, busy_d;

  logic             rep;
  logic             rep_bad;
  logic [2:0]       rep_cause;

  // Dibit payload is only counted, never inspected.
  logic unused_axiid;
  assign unused_axiid = ^axiid;

  always_comb begin
    state_d       = state_q;
    dibit_cnt_d   = dibit_cnt_q;
    giant_d       = giant_q;
    timer_d       = timer_q;
    ck_rst_d      = 1'b0;
    frame_ok_d    = 1'b0;
    frame_bad_d   = 1'b0;
    bad_cause_d   = bad_cause_q;
    frame_bytes_d = frame_bytes_q;
    good_count_d  = good_count_q;
    bad_count_d   = bad_count_q;
    rep           = 1'b0;
    rep_bad       = 1'b0;
    rep_cause     = C_CAUSE_CRC;

    case (state_q)
      IDLE: begin
        if (axiiv && !prev_axiiv_q) begin
          state_d     = RECV;
          dibit_cnt_d = {{(DW-1){1'b0}}, 1'b1};
          giant_d     = 1'b0;
        end
      end
      RECV: begin
        if (axiiv) begin
          if (dibit_cnt_q != C_SAT) dibit_cnt_d = dibit_cnt_q + 1'b1;
          giant_d = giant_q | (dibit_cnt_d == C_SAT);
        end else begin
          state_d = WAIT_CK;
          timer_d = '0;
        end
      end
      WAIT_CK: begin
        timer_d = timer_q + 1'b1;
        // A verdict arriving on the timeout cycle takes priority.
        if (ck_done) begin
          rep     = 1'b1;
          rep_bad = 1'b1;
          if (dibit_cnt_q[1:0] != 2'b00)          rep_cause = C_CAUSE_ALIGN;
          else if ((dibit_cnt_q >> 2) < C_MIN_BYTES) rep_cause = C_CAUSE_RUNT;
          else if (giant_q)                       rep_cause = C_CAUSE_GIANT;
          else if (ck_kill)                       rep_cause = C_CAUSE_CRC;
          else                                    rep_bad   = 1'b0;
        end else if (timer_q == C_TO_LAST) begin
          rep       = 1'b1;
          rep_bad   = 1'b1;
          rep_cause = C_CAUSE_TIMEOUT;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Verdict outputs are loaded on the edge that enters REPORT.
    if (rep) begin
      state_d       = REPORT;
      ck_rst_d      = 1'b1;
      frame_bytes_d = 11'(dibit_cnt_q >> 2);
      if (rep_bad) begin
        frame_bad_d = 1'b1;
        bad_cause_d = rep_cause;
        if (bad_count_q != {CNT_W{1'b1}}) bad_count_d = bad_count_q + 1'b1;
      end else begin
        frame_ok_d = 1'b1;
        if (good_count_q != {CNT_W{1'b1}}) good_count_d = good_count_q + 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_axiiv_q  <= 1'b1;
      dibit_cnt_q   <= '0;
      giant_q       <= 1'b0;
      timer_q       <= '0;
      ck_rst_q      <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_bad_q   <= 1'b0;
      bad_cause_q   <= '0;
      frame_bytes_q <= '0;
      good_count_q  <= '0;
      bad_count_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_axiiv_q  <= axiiv;
      dibit_cnt_q   <= dibit_cnt_d;
      giant_q       <= giant_d;
      timer_q       <= timer_d;
      ck_rst_q      <= ck_rst_d;
      frame_ok_q    <= frame_ok_d;
      frame_bad_q   <= frame_bad_d;
      bad_cause_q   <= bad_cause_d;
      frame_bytes_q <= frame_bytes_d;
      good_count_q  <= good_count_d;
      bad_count_q   <= bad_count_d;
      busy_q        <= busy_d;
    end
  end

  assign ck_rst      = ck_rst_q;
  assign frame_ok    = frame_ok_q;
  assign frame_bad   = frame_bad_q;
  assign bad_cause   = bad_cause_q;
  assign frame_bytes = frame_bytes_q;
  assign good_count  = good_count_q;
  assign bad_count   = bad_count_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
